// File: rtl/nx_dot6_accum.sv
// -----------------------------------------------------------------------------
// nx_dot6_accum
//
// Consumer-side companion to the 6-lane int8 dot-product unit. Each operand
// issue is tagged {valid, last}. The tag travels down a fixed-latency shift
// register that lines up with the dot unit's pipeline. When a valid tag reaches
// the tail, the 19-bit signed partial result is added into a wide accumulator.
// When the tail tag is also 'last', the finished vector sum and its chunk count
// are pushed into a small first-word-fall-through output FIFO.
//
// Issue is credit-gated. in_ready is asserted only while the FIFO occupancy
// plus the number of 'last' tags still in flight is below OUT_DEPTH. Every
// in-flight vector therefore has a FIFO slot reserved, and no result is
// dropped.
//
// Handshakes: a transfer happens on a rising clk edge when valid && ready are
// both high. Issue side: in_valid/in_ready, with in_last qualified by in_valid.
// Result side: out_valid/out_ready. in_ready and out_valid depend only on
// registered state (and on rst), never on in_valid or out_ready. A producer
// may therefore hold valid while it waits.
//
// Ports:
//   clk         clock
//   rst         asynchronous reset, active-high
//   in_valid    operands are issued to the dot unit this cycle
//   in_last     final chunk of the vector (qualified by in_valid)
//   in_ready    issue permitted this cycle
//   dot_result  signed dot6 output, sampled only when the tag tail is valid
//   out_valid   out_data/out_chunks hold a completed vector result
//   out_ready   downstream accepts the head result
//   out_data    signed accumulated dot product (ACC_W bits)
//   out_chunks  number of chunks summed into out_data (CNT_W bits)
// -----------------------------------------------------------------------------
module nx_dot6_accum #(
  parameter int DOT_LATENCY = 2,   // 1..8
  parameter int ACC_W       = 32,  // >= 19
  parameter int CNT_W       = 16,
  parameter int OUT_DEPTH   = 4    // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [18:0]      dot_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_chunks
);

  // ---------------------------------------------------------------------------
  // Derived widths
  // ---------------------------------------------------------------------------
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  // The credit sum can reach OUT_DEPTH + DOT_LATENCY, so leave headroom.
  localparam int CRED_W = $clog2(OUT_DEPTH + DOT_LATENCY + 1) + 1;

  // ---------------------------------------------------------------------------
  // Issue acceptance
  // ---------------------------------------------------------------------------
  logic acc_in;
  assign acc_in = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Tag pipeline. It never stalls. Index 0 is the newest tag and index
  // DOT_LATENCY-1 is the tail. The tail lines up with the cycle in which
  // dot_result carries the matching partial product.
  // ---------------------------------------------------------------------------
  logic [DOT_LATENCY-1:0] tag_v;
  logic [DOT_LATENCY-1:0] tag_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= acc_in;
      tag_l[0] <= acc_in && in_last;
      for (int i = 1; i < DOT_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  logic tail_v;
  logic tail_last;
  assign tail_v    = tag_v[DOT_LATENCY-1];
  assign tail_last = tag_l[DOT_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Accumulator and chunk counter
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] dot_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic        [CNT_W-1:0] chunk_cnt;
  logic        [CNT_W-1:0] cnt_inc;

  // Size-casting a signed operand sign-extends it to the accumulator width.
  assign dot_ext = ACC_W'($signed(dot_result));
  assign acc_sum = acc + dot_ext;               // wraps at ACC_W
  assign cnt_inc = chunk_cnt + CNT_W'(1);       // wraps at 2^CNT_W

  logic push;
  assign push = tail_v && tail_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      chunk_cnt <= '0;
    end else if (tail_v) begin
      if (tail_last) begin
        // The finished sum leaves through the FIFO push. Restart for the next
        // vector.
        acc       <= '0;
        chunk_cnt <= '0;
      end else begin
        acc       <= acc_sum;
        chunk_cnt <= cnt_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]  mem_data [OUT_DEPTH];
  logic [CNT_W-1:0]  mem_cnt  [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_count;
  logic              pop;

  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = mem_data[rd_ptr];
  assign out_chunks = mem_cnt[rd_ptr];

  // Storage is cleared on reset so the head reads as zero while the FIFO is
  // empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_cnt[i]  <= '0;
      end
    end else if (push) begin
      mem_data[wr_ptr] <= acc_sum;
      mem_cnt[wr_ptr]  <= cnt_inc;
    end
  end

  // Pointers wrap naturally because OUT_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;  // idle, or push+pop together
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Credits. Each 'last' tag in flight holds a reserved FIFO slot. This count
  // includes the tail tag, which is pushed at the coming edge. A push
  // therefore never targets a full FIFO. Non-last chunks consume no credit.
  // ---------------------------------------------------------------------------
  logic [CRED_W-1:0] inflight_last;
  logic [CRED_W-1:0] credits_used;

  always_comb begin
    inflight_last = '0;
    for (int i = 0; i < DOT_LATENCY; i++) begin
      inflight_last = inflight_last + CRED_W'(tag_l[i]);
    end
  end

  assign credits_used = CRED_W'(fifo_count) + inflight_last;
  assign in_ready     = !rst && (credits_used < CRED_W'(OUT_DEPTH));

endmodule

// File: tb/tb_nx_dot6_accum.sv
// -----------------------------------------------------------------------------
// tb_nx_dot6_accum
//
// Directed bench for nx_dot6_accum with default parameters. A small behavioural
// model of the dot unit delays the issued value by DOT_LATENCY cycles. The
// partial product then appears on dot_result exactly when the matching tag
// reaches the tail.
//
// Inputs change on the falling edge. Outputs are checked on the falling edge,
// halfway between active edges.
// -----------------------------------------------------------------------------
module tb_nx_dot6_accum;

  localparam int L     = 2;
  localparam int ACC_W = 32;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [18:0]      dot_result;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_chunks;

  nx_dot6_accum #(
    .DOT_LATENCY (L),
    .ACC_W       (ACC_W),
    .CNT_W       (CNT_W),
    .OUT_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .dot_result (dot_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chunks (out_chunks)
  );

  // Dot-unit stand-in. The value presented with an issue emerges L cycles
  // later.
  logic [18:0] issue_dot;
  logic [18:0] dpipe [L];
  always @(posedge clk) begin
    dpipe[0] <= issue_dot;
    for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
  end
  assign dot_result = dpipe[L-1];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks. Each is called on a falling edge and returns on the next
  // falling edge.
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic v, input logic l, input logic [18:0] d);
    in_valid  = v;
    in_last   = l;
    issue_dot = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 19'd0);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int accepts;
    int first_low;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    issue_dot = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_in_ready",   64'(in_ready),   64'd0);
    check("rst_out_data",   64'(out_data),   64'd0);
    check("rst_out_chunks", 64'(out_chunks), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 1. Single chunk. out_valid appears DOT_LATENCY+1 cycles after the accept.
    cyc(1'b1, 1'b1, 19'd5);
    idle(1);
    check("t1_not_yet_valid", 64'(out_valid), 64'd0);
    idle(1);
    check("t1_out_valid",  64'(out_valid),  64'd1);
    check("t1_out_data",   64'(out_data),   64'd5);
    check("t1_out_chunks", 64'(out_chunks), 64'd1);
    pop_one();
    check("t1_drained", 64'(out_valid), 64'd0);

    // 2. Three chunks: 98304 + (-50000) + 7 = 48311
    cyc(1'b1, 1'b0, 19'd98304);
    check("t2_no_mid_valid_a", 64'(out_valid), 64'd0);
    cyc(1'b1, 1'b0, 19'h73CB0);  // -50000
    check("t2_no_mid_valid_b", 64'(out_valid), 64'd0);
    cyc(1'b1, 1'b1, 19'd7);
    check("t2_no_mid_valid_c", 64'(out_valid), 64'd0);
    idle(1);
    check("t2_no_mid_valid_d", 64'(out_valid), 64'd0);
    idle(1);
    check("t2_out_valid",  64'(out_valid),  64'd1);
    check("t2_out_data",   64'(out_data),   64'd48311);
    check("t2_out_chunks", 64'(out_chunks), 64'd3);
    pop_one();
    check("t2_drained", 64'(out_valid), 64'd0);

    // 3. Sign extension of the most negative 19-bit value
    cyc(1'b1, 1'b1, 19'h40000);
    idle(2);
    check("t3_out_valid",  64'(out_valid),  64'd1);
    check("t3_out_data",   64'(out_data),   64'h0000_0000_FFFC_0000);
    check("t3_out_chunks", 64'(out_chunks), 64'd1);
    pop_one();

    // 4. Credit backpressure. Single-chunk vectors are offered every cycle
    //    while out_ready is held low.
    accepts   = 0;
    first_low = -1;
    for (int k = 0; k < 10; k++) begin
      if (!in_ready && first_low < 0) first_low = k;
      if (in_ready) begin
        cyc(1'b1, 1'b1, 19'(accepts + 1));
        accepts++;
      end else begin
        cyc(1'b1, 1'b1, 19'd0);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t4_accepts",      64'(accepts),   64'd4);
    check("t4_first_low",    64'(first_low), 64'd4);
    check("t4_ready_held",   64'(in_ready),  64'd0);
    out_ready = 1'b1;
    check("t4_head1_valid",  64'(out_valid), 64'd1);
    check("t4_head1",        64'(out_data),  64'd1);
    cyc(1'b0, 1'b0, 19'd0);
    check("t4_ready_back",   64'(in_ready),  64'd1);
    check("t4_head2",        64'(out_data),  64'd2);
    cyc(1'b0, 1'b0, 19'd0);
    check("t4_head3",        64'(out_data),  64'd3);
    cyc(1'b0, 1'b0, 19'd0);
    check("t4_head4",        64'(out_data),  64'd4);
    check("t4_head4_chunks", 64'(out_chunks), 64'd1);
    cyc(1'b0, 1'b0, 19'd0);
    check("t4_empty",        64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // 5. Bubbles. Values seen on bubble slots must not contribute.
    cyc(1'b1, 1'b0, 19'd3);
    cyc(1'b0, 1'b0, 19'd1000);
    cyc(1'b0, 1'b0, 19'd1000);
    cyc(1'b1, 1'b1, 19'd3);
    idle(2);
    check("t5_out_valid",  64'(out_valid),  64'd1);
    check("t5_out_data",   64'(out_data),   64'd6);
    check("t5_out_chunks", 64'(out_chunks), 64'd2);
    pop_one();

    // 6. Reset mid-vector discards the partial sum.
    cyc(1'b1, 1'b0, 19'd50);
    cyc(1'b1, 1'b0, 19'd50);
    rst = 1'b1;
    idle(1);
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    idle(1);
    cyc(1'b1, 1'b1, 19'd9);
    idle(2);
    check("t6_out_valid",  64'(out_valid),  64'd1);
    check("t6_out_data",   64'(out_data),   64'd9);
    check("t6_out_chunks", 64'(out_chunks), 64'd1);
    pop_one();

    // ---------------------------------------------------------------------------
    // Final report
    // ---------------------------------------------------------------------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
